i2c_codec_reg_slave: RTL and testbench

- I2C write-only responder that models the audio codec control port. It is the target end of the 24-bit {slave address, register address, data} writes issued by the codec configuration master.
- SCL and SDA are oversampled on iCLK.
- It decodes START and STOP, matches the 7-bit device address and drives ACK.
- It assembles each 16-bit control word as a 7-bit register address plus 9-bit data, and stores it in a small register file with a readback port.
- Used as a bench/loopback model and as a codec stand-in in FPGA builds without a codec.

---
 rtl/i2c_codec_reg_slave.sv | 190 +++++++++++++++++++
 tb/tb_i2c_codec_reg_slave.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_codec_reg_slave.sv
// Write-only I2C target modelling an audio codec control port.
// Accepts {addr, reg[6:0]+d[8], d[7:0]} writes into a small register file with readback.
module i2c_codec_reg_slave #(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h1A,
    parameter int unsigned REG_COUNT   = 10,
    parameter logic [6:0]  RESET_REG   = 7'h0F,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       I2C_SCLK,
    input  logic       I2C_SDAT_IN,
    output logic       oSDA_OE,
    output logic       oREG_WR,
    output logic [6:0] oREG_ADDR,
    output logic [8:0] oREG_DATA,
    output logic       oRESET_CMD,
    output logic       oERR,
    output logic       oBUSY,
    input  logic [3:0] iRD_ADDR,
    output logic [8:0] oRD_DATA
);

    typedef enum logic [2:0] {
        StIdle, StAddr, StAckA, StByte1, StAck1, StByte2, StAck2, StWaitStop
    } state_e;

    localparam logic [7:0] RegCountW = 8'(REG_COUNT);

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic scl_s, sda_s, scl_d1_q, sda_d1_q;
    logic scl_rise, scl_fall, start_det, stop_det, incomplete;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [6:0] shift_q, shift_d;
    logic [7:0] b1_q, b1_d, byte_in;
    logic       oe_q, oe_d, busy_q, busy_d;
    logic       wr_q, wr_d, rst_cmd_q, rst_cmd_d, err_q, err_d;
    logic [6:0] reg_addr_q, reg_addr_d;
    logic [8:0] reg_data_q, reg_data_d;
    logic       reg_we, reg_clr;
    logic [8:0] regs_q [REG_COUNT];

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s && !scl_d1_q;
    assign scl_fall  = !scl_s && scl_d1_q;
    // Bus conditions require SCL high in both samples so an SCL edge never masquerades as one.
    assign start_det = scl_s && scl_d1_q && sda_d1_q && !sda_s;
    assign stop_det  = scl_s && scl_d1_q && !sda_d1_q && sda_s;
    assign byte_in   = {shift_q, sda_s};
    assign incomplete = (state_q == StByte1) || (state_q == StAck1) || (state_q == StByte2);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        b1_d       = b1_q;
        oe_d       = oe_q;
        busy_d     = busy_q;
        wr_d       = 1'b0;
        rst_cmd_d  = 1'b0;
        err_d      = 1'b0;
        reg_addr_d = reg_addr_q;
        reg_data_d = reg_data_q;
        reg_we     = 1'b0;
        reg_clr    = 1'b0;
        if (stop_det) begin
            state_d = StIdle;
            cnt_d   = '0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            err_d   = incomplete;
        end else if (start_det) begin
            state_d = StAddr;
            cnt_d   = '0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            err_d   = incomplete;
        end else begin
            unique case (state_q)
                StIdle, StWaitStop: ;
                StAddr, StByte1, StByte2: begin
                    if (scl_rise) begin
                        shift_d = byte_in[6:0];
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            if (state_q == StAddr) begin
                                if (byte_in == {SLAVE_ADDR, 1'b0}) begin
                                    busy_d  = 1'b1;
                                    state_d = StAckA;
                                end else begin
                                    state_d = StIdle;
                                end
                            end else if (state_q == StByte1) begin
                                b1_d    = byte_in;
                                state_d = StAck1;
                            end else begin
                                reg_addr_d = b1_q[7:1];
                                reg_data_d = {b1_q[0], byte_in};
                                if (b1_q[7:1] == RESET_REG) begin
                                    reg_clr   = 1'b1;
                                    rst_cmd_d = 1'b1;
                                end else if ({1'b0, b1_q[7:1]} < RegCountW) begin
                                    reg_we = 1'b1;
                                    wr_d   = 1'b1;
                                end
                                state_d = StAck2;
                            end
                        end
                    end
                end
                StAckA, StAck1, StAck2: begin
                    // First SCL fall drives ACK, the following fall releases it.
                    if (scl_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else begin
                            oe_d  = 1'b0;
                            cnt_d = '0;
                            state_d = (state_q == StAckA) ? StByte1 :
                                      (state_q == StAck1) ? StByte2 : StWaitStop;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_d1_q   <= 1'b1;
            sda_d1_q   <= 1'b1;
            state_q    <= StIdle;
            cnt_q      <= '0;
            shift_q    <= '0;
            b1_q       <= '0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            wr_q       <= 1'b0;
            rst_cmd_q  <= 1'b0;
            err_q      <= 1'b0;
            reg_addr_q <= '0;
            reg_data_q <= '0;
            for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], I2C_SCLK};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], I2C_SDAT_IN};
            scl_d1_q   <= scl_s;
            sda_d1_q   <= sda_s;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            b1_q       <= b1_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            wr_q       <= wr_d;
            rst_cmd_q  <= rst_cmd_d;
            err_q      <= err_d;
            reg_addr_q <= reg_addr_d;
            reg_data_q <= reg_data_d;
            for (int i = 0; i < REG_COUNT; i++) begin
                if (reg_clr) begin
                    regs_q[i] <= '0;
                end else if (reg_we && (reg_addr_d == 7'(i))) begin
                    regs_q[i] <= reg_data_d;
                end
            end
        end
    end

    always_comb begin
        oRD_DATA = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (iRD_ADDR == 4'(i)) oRD_DATA = regs_q[i];
        end
    end

    assign oSDA_OE    = oe_q;
    assign oREG_WR    = wr_q;
    assign oREG_ADDR  = reg_addr_q;
    assign oREG_DATA  = reg_data_q;
    assign oRESET_CMD = rst_cmd_q;
    assign oERR       = err_q;
    assign oBUSY      = busy_q;

endmodule

// File: tb/tb_i2c_codec_reg_slave.sv
// Bench for i2c_codec_reg_slave: bit-banged I2C master, open-drain SDA and a register-file model.
module tb_i2c_codec_reg_slave;

    localparam int Q = 8;  // clocks per quarter SCL period

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic [3:0] rd_addr = 4'd0;
    logic       oe, reg_wr, reset_cmd, err, busy;
    logic [6:0] reg_addr;
    logic [8:0] reg_data, rd_data;
    wire        sda_in = sda_m & ~oe;

    int tests = 0;
    int fails = 0;
    int wr_cnt = 0, rst_cnt = 0, err_cnt = 0, oe_rise_cnt = 0, oe_viol = 0;
    logic prev_oe = 1'b0;
    logic [8:0] model_regs [10];

    i2c_codec_reg_slave dut (
        .iCLK        (clk),
        .iRST_N      (rst_n),
        .I2C_SCLK    (scl),
        .I2C_SDAT_IN (sda_in),
        .oSDA_OE     (oe),
        .oREG_WR     (reg_wr),
        .oREG_ADDR   (reg_addr),
        .oREG_DATA   (reg_data),
        .oRESET_CMD  (reset_cmd),
        .oERR        (err),
        .oBUSY       (busy),
        .iRD_ADDR    (rd_addr),
        .oRD_DATA    (rd_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reg_wr === 1'b1) wr_cnt <= wr_cnt + 1;
        if (reset_cmd === 1'b1) rst_cnt <= rst_cnt + 1;
        if (err === 1'b1) err_cnt <= err_cnt + 1;
        if (oe === 1'b1 && prev_oe === 1'b0) oe_rise_cnt <= oe_rise_cnt + 1;
        if (rst_n && scl && oe !== prev_oe) oe_viol <= oe_viol + 1;
        prev_oe <= oe;
    end

    function automatic logic [8:0] model_rd(int a);
        return (a < 10) ? model_regs[a] : 9'h000;
    endfunction

    task automatic model_write(input logic [6:0] a, input logic [8:0] d);
        if (a == 7'h0F) begin
            foreach (model_regs[i]) model_regs[i] = 9'h000;
        end else if (a < 7'd10) begin
            model_regs[a] = d;
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wait_q();
        scl = 1'b1;   wait_q();
        sda_m = 1'b0; wait_q();
        scl = 1'b0;   wait_q();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_q();
        scl = 1'b1;   wait_q();
        sda_m = 1'b1; wait_q();
        wait_q();
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sda_m = b[i]; wait_q();
            scl = 1'b1;   wait_q(); wait_q();
            scl = 1'b0;   wait_q();
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        sda_m = 1'b1; wait_q();
        scl = 1'b1;   wait_q();
        ack = (sda_in === 1'b0);
        wait_q();
        scl = 1'b0;   wait_q();
    endtask

    // START then the first n bytes of `bytes` (MSB byte first); leaves the bus held, no STOP.
    task automatic run_txn(input logic [31:0] bytes, input int n, output logic [3:0] acks);
        logic a;
        acks = 4'b0000;
        bus_start();
        for (int k = 0; k < n; k++) begin
            send_byte(bytes[31-8*k -: 8], a);
            acks[k] = a;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; scl = 1'b1; sda_m = 1'b1;
        foreach (model_regs[i]) model_regs[i] = 9'h000;
        repeat (3) @(negedge clk);
        tests++;
        if ({oe, reg_wr, reset_cmd, err, busy} !== 5'b0) begin
            fails++; $display("FAIL reset_ctrl: got %b want 00000", {oe, reg_wr, reset_cmd, err, busy});
        end
        tests++;
        if ({reg_addr, reg_data} !== 16'h0) begin
            fails++; $display("FAIL reset_word: got %h/%h want 00/000", reg_addr, reg_data);
        end
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i); #1;
            tests++;
            if (rd_data !== 9'h000) begin
                fails++; $display("FAIL reset_reg%0d: got %h want 000", i, rd_data);
            end
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic_write();
        logic [3:0] acks;
        int w0;
        w0 = wr_cnt;
        run_txn(32'h3404FA00, 3, acks);
        tests++;
        if (acks !== 4'b0111) begin fails++; $display("FAIL basic_acks: got %b want 0111", acks); end
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy: got %b want 1", busy); end
        bus_stop();
        model_write(7'h02, 9'h0FA);
        tests++;
        if (wr_cnt - w0 != 1) begin fails++; $display("FAIL basic_wr: got %0d want 1", wr_cnt - w0); end
        tests++;
        if (reg_addr !== 7'h02 || reg_data !== 9'h0FA) begin
            fails++; $display("FAIL basic_word: got %h/%h want 02/0fa", reg_addr, reg_data);
        end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_stop: got %b want 0", busy); end
        rd_addr = 4'd2; #1;
        tests++;
        if (rd_data !== model_rd(2)) begin fails++; $display("FAIL basic_rd2: got %h want %h", rd_data, model_rd(2)); end
        w0 = wr_cnt;
        run_txn(32'h34130100, 3, acks);
        bus_stop();
        model_write(7'h09, 9'h101);
        tests++;
        if (acks !== 4'b0111 || wr_cnt - w0 != 1) begin
            fails++; $display("FAIL reg9_txn: got acks %b wr %0d want 0111 1", acks, wr_cnt - w0);
        end
        tests++;
        if (reg_addr !== 7'h09 || reg_data !== 9'h101) begin
            fails++; $display("FAIL reg9_word: got %h/%h want 09/101", reg_addr, reg_data);
        end
        rd_addr = 4'd9; #1;
        tests++;
        if (rd_data !== 9'h101) begin fails++; $display("FAIL reg9_rd: got %h want 101", rd_data); end
    endtask

    task automatic test_wrong_addr();
        logic [3:0] acks;
        int w0, o0;
        w0 = wr_cnt; o0 = oe_rise_cnt;
        run_txn(32'h3604FA00, 3, acks);
        tests++;
        if (acks !== 4'b0000 || busy !== 1'b0) begin
            fails++; $display("FAIL wrong_addr: got acks %b busy %b want 0000 0", acks, busy);
        end
        bus_stop();
        run_txn(32'h3504FA00, 3, acks);
        tests++;
        if (acks !== 4'b0000 || busy !== 1'b0) begin
            fails++; $display("FAIL read_req: got acks %b busy %b want 0000 0", acks, busy);
        end
        bus_stop();
        tests++;
        if (wr_cnt != w0 || oe_rise_cnt != o0) begin
            fails++; $display("FAIL nack_side: got wr %0d oe %0d want 0 0", wr_cnt - w0, oe_rise_cnt - o0);
        end
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i); #1;
            tests++;
            if (rd_data !== model_rd(i)) begin
                fails++; $display("FAIL nack_reg%0d: got %h want %h", i, rd_data, model_rd(i));
            end
        end
    endtask

    task automatic test_reset_reg();
        logic [3:0] acks;
        int w0, r0;
        run_txn(32'h3404FA00, 3, acks); bus_stop();
        model_write(7'h02, 9'h0FA);
        w0 = wr_cnt; r0 = rst_cnt;
        run_txn(32'h341E0000, 3, acks); bus_stop();
        model_write(7'h0F, 9'h000);
        tests++;
        if (rst_cnt - r0 != 1 || wr_cnt != w0) begin
            fails++; $display("FAIL reset_cmd: got rst %0d wr %0d want 1 0", rst_cnt - r0, wr_cnt - w0);
        end
        tests++;
        if (acks !== 4'b0111) begin fails++; $display("FAIL reset_cmd_acks: got %b want 0111", acks); end
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i); #1;
            tests++;
            if (rd_data !== model_rd(i)) begin
                fails++; $display("FAIL clr_reg%0d: got %h want %h", i, rd_data, model_rd(i));
            end
        end
    endtask

    task automatic test_abort();
        logic [3:0] acks;
        int w0, e0;
        run_txn(32'h34043300, 3, acks); bus_stop();
        model_write(7'h02, 9'h033);
        w0 = wr_cnt; e0 = err_cnt;
        run_txn(32'h3404FA00, 2, acks); bus_stop();
        tests++;
        if (err_cnt - e0 != 1 || wr_cnt != w0) begin
            fails++; $display("FAIL abort: got err %0d wr %0d want 1 0", err_cnt - e0, wr_cnt - w0);
        end
        rd_addr = 4'd2; #1;
        tests++;
        if (rd_data !== 9'h033) begin fails++; $display("FAIL abort_reg2: got %h want 033", rd_data); end
        e0 = err_cnt;
        run_txn(32'h340E4B77, 4, acks);
        tests++;
        if (acks !== 4'b0111 || busy !== 1'b1) begin
            fails++; $display("FAIL extra_byte: got acks %b busy %b want 0111 1", acks, busy);
        end
        bus_stop();
        model_write(7'h07, 9'h04B);
        rd_addr = 4'd7; #1;
        tests++;
        if (rd_data !== 9'h04B || busy !== 1'b0 || err_cnt != e0) begin
            fails++; $display("FAIL extra_end: got %h busy %b err %0d want 04b 0 0", rd_data, busy, err_cnt - e0);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] acks;
        int w0, e0;
        w0 = wr_cnt; e0 = err_cnt;
        run_txn(32'h34040000, 2, acks);
        run_txn(32'h34065500, 3, acks);
        bus_stop();
        model_write(7'h03, 9'h055);
        tests++;
        if (err_cnt - e0 != 1 || wr_cnt - w0 != 1 || acks !== 4'b0111) begin
            fails++; $display("FAIL rstart: got err %0d wr %0d acks %b want 1 1 0111",
                              err_cnt - e0, wr_cnt - w0, acks);
        end
        rd_addr = 4'd3; #1;
        tests++;
        if (rd_data !== 9'h055) begin fails++; $display("FAIL rstart_reg3: got %h want 055", rd_data); end
    endtask

    task automatic test_random();
        logic [3:0] acks, exp_acks;
        logic [7:0] ab, b1, b2;
        logic       match;
        int nb, w0, r0, e0, exp_wr, exp_rst, exp_err;
        for (int it = 0; it < 16; it++) begin
            ab = ($urandom_range(0, 3) != 0) ? 8'h34 : 8'($urandom_range(0, 255));
            b1 = {3'($urandom_range(0, 7)) == 3'd0 ? 7'h0F : 7'($urandom_range(0, 14)),
                  1'($urandom_range(0, 1))};
            b2 = 8'($urandom_range(0, 255));
            nb = $urandom_range(0, 3);
            match = (ab == 8'h34);
            exp_acks = 4'b0000;
            for (int k = 0; k <= nb; k++) exp_acks[k] = match && (k < 3);
            exp_wr  = (match && nb >= 2 && b1[7:1] < 7'd10) ? 1 : 0;
            exp_rst = (match && nb >= 2 && b1[7:1] == 7'h0F) ? 1 : 0;
            exp_err = (match && nb < 2) ? 1 : 0;
            w0 = wr_cnt; r0 = rst_cnt; e0 = err_cnt;
            run_txn({ab, b1, b2, 8'hA5}, nb + 1, acks);
            tests++;
            if (acks !== exp_acks || busy !== match) begin
                fails++; $display("FAIL rnd%0d_acks: got %b busy %b want %b %b", it, acks, busy, exp_acks, match);
            end
            bus_stop();
            if (match && nb >= 2) begin
                model_write(b1[7:1], {b1[0], b2});
                tests++;
                if (reg_addr !== b1[7:1] || reg_data !== {b1[0], b2}) begin
                    fails++; $display("FAIL rnd%0d_word: got %h/%h want %h/%h", it, reg_addr, reg_data,
                                      b1[7:1], {b1[0], b2});
                end
            end
            tests++;
            if (wr_cnt - w0 != exp_wr || rst_cnt - r0 != exp_rst || err_cnt - e0 != exp_err) begin
                fails++; $display("FAIL rnd%0d_pulses: got %0d/%0d/%0d want %0d/%0d/%0d", it,
                                  wr_cnt - w0, rst_cnt - r0, err_cnt - e0, exp_wr, exp_rst, exp_err);
            end
            for (int i = 0; i < 16; i++) begin
                rd_addr = 4'(i); #1;
                tests++;
                if (rd_data !== model_rd(i)) begin
                    fails++; $display("FAIL rnd%0d_reg%0d: got %h want %h", it, i, rd_data, model_rd(i));
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [3:0] acks;
        logic       a;
        int w0;
        run_txn(32'h34130100, 3, acks); bus_stop();
        model_write(7'h09, 9'h101);
        run_txn(32'h3404FA00, 2, acks);
        send_bits(8'hFA, 4);
        rst_n = 1'b0; #1;
        foreach (model_regs[i]) model_regs[i] = 9'h000;
        tests++;
        if (oe !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL midrst_out: got oe %b busy %b want 0 0", oe, busy);
        end
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i); #1;
            tests++;
            if (rd_data !== 9'h000) begin fails++; $display("FAIL midrst_reg%0d: got %h want 000", i, rd_data); end
        end
        sda_m = 1'b1; scl = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        // Reset while ACK is being driven must release SDA without waiting for a clock.
        bus_start();
        send_bits(8'h34, 8);
        sda_m = 1'b1; wait_q();
        scl = 1'b1; wait_q();
        tests++;
        if (oe !== 1'b1) begin fails++; $display("FAIL ack_drive: got %b want 1", oe); end
        rst_n = 1'b0; #1;
        tests++;
        if (oe !== 1'b0) begin fails++; $display("FAIL ackrst_release: got %b want 0", oe); end
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        w0 = wr_cnt;
        run_txn(32'h3404FA00, 3, acks);
        bus_stop();
        model_write(7'h02, 9'h0FA);
        rd_addr = 4'd2; #1;
        tests++;
        if (acks !== 4'b0111 || wr_cnt - w0 != 1 || rd_data !== 9'h0FA) begin
            fails++; $display("FAIL post_rst: got acks %b wr %0d rd %h want 0111 1 0fa", acks, wr_cnt - w0, rd_data);
        end
        send_byte(8'h00, a);
    endtask

    task automatic test_oe_timing();
        tests++;
        if (oe_viol != 0) begin fails++; $display("FAIL oe_scl_high: got %0d changes want 0", oe_viol); end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_wrong_addr();
        test_reset_reg();
        test_abort();
        test_back_to_back();
        test_random();
        test_mid_reset();
        test_oe_timing();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
